// File: rtl/f_fetch_stage_pkg.sv
// rtl/f_fetch_stage_pkg.sv - shared next-PC select encodings and reset PC
// Imported by the fetch stage and by the decode-stage controller.
package f_fetch_stage_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/f_fetch_stage_if.sv
// rtl/f_fetch_stage_if.sv - instruction memory read port between fetch and memory
// Read data is combinational on the address within the same cycle.
interface f_fetch_stage_if;

  logic [31:0] InstrMem_Addr;
  logic [31:0] InstrMem_Rdata;

  modport master (output InstrMem_Addr, input InstrMem_Rdata);
  modport slave  (input InstrMem_Addr, output InstrMem_Rdata);

endinterface

// File: rtl/f_fetch_stage_npc.sv
// rtl/f_fetch_stage_npc.sv - f_npc, purely combinational next-PC calculator
// Branch and jump targets are formed from the decode-stage PC so the delay slot is kept.
module f_npc
  import f_fetch_stage_pkg::*;
(
  input  logic [31:0] pc_f,
  input  npc_op_e     npc_op,
  input  logic        branch_taken,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] reg_rs,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;

  always_comb begin
    seq_pc        = pc_f + 32'd4;
    branch_target = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    jump_target   = {pc_d[31:28], index26, 2'b00};
    npc           = seq_pc;
    case (npc_op)
      NPC_SEQ:    npc = seq_pc;
      NPC_BRANCH: npc = branch_taken ? branch_target : seq_pc;
      NPC_JUMP:   npc = jump_target;
      NPC_JR:     npc = reg_rs;
      default:    npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/f_fetch_stage.sv
// rtl/f_fetch_stage.sv - instruction fetch stage: PC register, next-PC select, imem read
// Optional fetch address-error check enabled by defining F_ADEL_CHECK_EN.
module f_fetch_stage
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Stop_F,
  input  logic [1:0]    NPCOp_D,
  input  logic          BranchTaken_D,
  input  logic [31:0]   PC_D,
  input  logic [15:0]   Imm16_D,
  input  logic [25:0]   Index26_D,
  input  logic [31:0]   RegRs_D,
  f_fetch_stage_if.master imem,
  output logic [31:0]   Instr_F,
  output logic [31:0]   PC_F,
  output logic [31:0]   PCPlus4_F
`ifdef F_ADEL_CHECK_EN
  ,
  output logic          ExcAdEL_F
`endif
);

  logic [31:0] pc_q;
  logic [31:0] npc;

  f_npc u_npc (
    .pc_f         (pc_q),
    .npc_op       (npc_op_e'(NPCOp_D)),
    .branch_taken (BranchTaken_D),
    .pc_d         (PC_D),
    .imm16        (Imm16_D),
    .index26      (Index26_D),
    .reg_rs       (RegRs_D),
    .npc          (npc)
  );

  // Stall beats redirect; reset beats both.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (!Stop_F) begin
      pc_q <= npc;
    end
  end

  assign PC_F               = pc_q;
  assign PCPlus4_F          = pc_q + 32'd4;
  assign imem.InstrMem_Addr = pc_q;

`ifdef F_ADEL_CHECK_EN
  // 33-bit compare so a window ending exactly at 2^32 is still representable.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_WORDS) * 33'd4;

  logic adel;

  always_comb begin
    adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_LIMIT);
  end

  assign ExcAdEL_F = adel;
  assign Instr_F   = adel ? 32'h0000_0000 : imem.InstrMem_Rdata;
`else
  assign Instr_F   = imem.InstrMem_Rdata;
`endif

endmodule

// File: tb/tb_f_fetch_stage.sv
// tb/tb_f_fetch_stage.sv - directed and random checks of f_fetch_stage against a reference model
// Covers F_ADEL_CHECK_EN builds as well as the default build.
module tb_f_fetch_stage;
  import f_fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] BASE   = 32'h0000_3000;
  localparam int          WORDS  = 4096;
  localparam logic [31:0] KEY    = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stop_F;
  logic [1:0]  NPCOp_D;
  logic        BranchTaken_D;
  logic [31:0] PC_D;
  logic [15:0] Imm16_D;
  logic [25:0] Index26_D;
  logic [31:0] RegRs_D;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PCPlus4_F;
`ifdef F_ADEL_CHECK_EN
  logic        ExcAdEL_F;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  f_fetch_stage_if imem ();
  assign imem.InstrMem_Rdata = imem.InstrMem_Addr ^ KEY;

  f_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .Stop_F        (Stop_F),
    .NPCOp_D       (NPCOp_D),
    .BranchTaken_D (BranchTaken_D),
    .PC_D          (PC_D),
    .Imm16_D       (Imm16_D),
    .Index26_D     (Index26_D),
    .RegRs_D       (RegRs_D),
    .imem          (imem),
    .Instr_F       (Instr_F),
    .PC_F          (PC_F),
    .PCPlus4_F     (PCPlus4_F)
`ifdef F_ADEL_CHECK_EN
    ,
    .ExcAdEL_F     (ExcAdEL_F)
`endif
  );

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] op,
                                           input logic taken, input logic [31:0] pcd,
                                           input logic [15:0] imm, input logic [25:0] idx,
                                           input logic [31:0] rs);
    int offset;
    offset = int'($signed(imm)) * 4;
    case (op)
      2'd1:    return taken ? (pcd + 32'd4 + 32'(offset)) : (pc + 32'd4);
      2'd2:    return (pcd & 32'hF000_0000) | (32'(idx) * 32'd4);
      2'd3:    return rs;
      default: return pc + 32'd4;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [31:0] pc);
    longint off;
    off = longint'(pc) - longint'(BASE);
    return (pc % 4 == 0) && (off >= 0) && (off < longint'(WORDS) * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_instr;
    exp_instr = m_pc ^ KEY;
`ifdef F_ADEL_CHECK_EN
    if (!ref_legal(m_pc)) exp_instr = 32'h0000_0000;
    chk("ExcAdEL_F", {31'd0, ExcAdEL_F}, {31'd0, !ref_legal(m_pc)});
`endif
    chk("PC_F", PC_F, m_pc);
    chk("PCPlus4_F", PCPlus4_F, m_pc + 32'd4);
    chk("InstrMem_Addr", imem.InstrMem_Addr, m_pc);
    chk("Instr_F", Instr_F, exp_instr);
  endtask

  task automatic step(input logic rst, input logic stop, input logic [1:0] op, input logic taken,
                      input logic [31:0] pcd, input logic [15:0] imm, input logic [25:0] idx,
                      input logic [31:0] rs);
    logic [31:0] nxt;
    reset = rst; Stop_F = stop; NPCOp_D = op; BranchTaken_D = taken;
    PC_D = pcd; Imm16_D = imm; Index26_D = idx; RegRs_D = rs;
    nxt = ref_next(m_pc, op, taken, pcd, imm, idx, rs);
    @(posedge clk);
    if (rst) m_pc = RST_PC;
    else if (!stop) m_pc = nxt;
    #1;
    check_all();
  endtask

  initial begin
    m_pc = 32'hDEAD_BEEF;
    step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h1234_5678);
    step(1'b1, 1'b0, NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    chk("reset_pc", PC_F, 32'h0000_3000);
    chk("reset_pc4", PCPlus4_F, 32'h0000_3004);
    step(1'b0, 1'b0, NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    chk("seq_1", PC_F, 32'h0000_3004);
    step(1'b0, 1'b0, NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    chk("seq_2", PC_F, 32'h0000_3008);
    step(1'b0, 1'b0, NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    step(1'b0, 1'b0, NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    chk("pre_stall", PC_F, 32'h0000_3010);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      chk("stall_hold", PC_F, 32'h0000_3010);
    end
    step(1'b0, 1'b0, NPC_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
    chk("stall_release", PC_F, 32'h0000_3014);
    step(1'b0, 1'b0, NPC_BRANCH, 1'b1, 32'h0000_3020, 16'hFFFC, 26'h0, 32'h0);
    chk("branch_taken", PC_F, 32'h0000_3014);
    step(1'b0, 1'b0, NPC_BRANCH, 1'b0, 32'h0000_3020, 16'hFFFC, 26'h0, 32'h0);
    chk("branch_not_taken", PC_F, 32'h0000_3018);
    step(1'b0, 1'b0, NPC_JUMP, 1'b0, 32'h0000_3040, 16'h0, 26'h0C10, 32'h0);
    chk("jump", PC_F, 32'h0000_3040);
    step(1'b0, 1'b0, NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3100);
    chk("jr", PC_F, 32'h0000_3100);
    step(1'b0, 1'b1, NPC_JUMP, 1'b0, 32'h0000_3040, 16'h0, 26'h0C20, 32'h0);
    chk("stall_jump_hold", PC_F, 32'h0000_3100);
    step(1'b0, 1'b0, NPC_JUMP, 1'b0, 32'h0000_3040, 16'h0, 26'h0C20, 32'h0);
    chk("stall_jump_load", PC_F, 32'h0000_3080);
    step(1'b1, 1'b1, NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_5000);
    chk("reset_wins", PC_F, 32'h0000_3000);
    step(1'b0, 1'b0, NPC_BRANCH, 1'b1, 32'hFFFF_FFF8, 16'h0001, 26'h0, 32'h0);
    chk("branch_wrap", PC_F, 32'h0000_0000);
`ifdef F_ADEL_CHECK_EN
    step(1'b0, 1'b0, NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3102);
    chk("adel_misaligned", {31'd0, ExcAdEL_F}, 32'd1);
    chk("adel_nop", Instr_F, 32'h0000_0000);
    step(1'b0, 1'b0, NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_7000);
    chk("adel_range", {31'd0, ExcAdEL_F}, 32'd1);
    step(1'b0, 1'b0, NPC_JR, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0000_3000);
    chk("adel_legal", {31'd0, ExcAdEL_F}, 32'd0);
`endif
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs;
      logic [31:0] pcd;
      rs  = ($urandom_range(0, 1) == 0) ? (BASE + 32'($urandom_range(0, WORDS - 1)) * 32'd4)
                                         : $urandom;
      pcd = ($urandom_range(0, 3) == 0) ? $urandom : m_pc - 32'd4;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pcd,
           16'($urandom), 26'($urandom), rs);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/f_fetch_stage.md
F_FETCH_STAGE -- requirements
Module: f_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, value of PC_F after reset.
REQ-002 Parameter IM_BASE, default 32'h0000_3000, lowest legal fetch address.
REQ-003 Parameter IM_WORDS, default 4096, instruction memory depth in words.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 Stop_F  in  1  stall; 1 = hold PC this cycle.
REQ-007 NPCOp_D  in  2  next-PC select from decode: 0 SEQ, 1 BRANCH, 2 JUMP (j/jal), 3 JR.
REQ-008 BranchTaken_D  in  1  branch condition result for the decode-stage instruction.
REQ-009 PC_D  in  32  PC of the instruction in decode.
REQ-010 Imm16_D  in  16  branch offset field.
REQ-011 Index26_D  in  26  jump index field.
REQ-012 RegRs_D  in  32  forwarded rs value, the jr target.
REQ-013 InstrMem_Rdata  in  32  combinational instruction memory read data for InstrMem_Addr.
REQ-014 InstrMem_Addr  out  32  fetch address, equal to PC_F.
REQ-015 Instr_F  out  32  fetched instruction, delivered to the IF/ID register.
REQ-016 PC_F  out  32  current fetch PC.
REQ-017 PCPlus4_F  out  32  PC_F + 4, modulo 2^32.
REQ-018 ExcAdEL_F  out  1  fetch address error; present only when F_ADEL_CHECK_EN is defined.

Function
REQ-019 PC_F SHALL be a 32-bit register; all other outputs SHALL be combinational from PC_F and the inputs.
REQ-020 SEQ: next PC SHALL be PC_F + 4.
REQ-021 BRANCH with BranchTaken_D=1: next PC SHALL be PC_D + 4 + (sign-extended Imm16_D << 2), with the delay slot preserved.
REQ-022 BRANCH with BranchTaken_D=0: next PC SHALL be PC_F + 4.
REQ-023 JUMP: next PC SHALL be {PC_D[31:28], Index26_D, 2'b00}.
REQ-024 JR: next PC SHALL be RegRs_D, unmodified.
REQ-025 On a rising edge with Stop_F=1, PC_F SHALL hold, even when NPCOp_D is not SEQ; stall overrides redirect.
REQ-026 Otherwise PC_F SHALL load the next PC at every rising edge; no fetch bubble SHALL be inserted on a redirect.
REQ-027 Instr_F SHALL equal InstrMem_Rdata with zero added latency, except as stated in REQ-033.
REQ-028 All additions SHALL wrap modulo 2^32, with no overflow flag.

Reset
REQ-029 When reset=1 at a rising edge, PC_F SHALL become RESET_PC, regardless of Stop_F and NPCOp_D.
REQ-030 After reset, PCPlus4_F SHALL be RESET_PC+4, and InstrMem_Addr SHALL be RESET_PC.
REQ-031 After reset, ExcAdEL_F SHALL be 0 when RESET_PC is legal.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL win over both.

Configuration
REQ-033 With F_ADEL_CHECK_EN defined, the block SHALL assert ExcAdEL_F when PC_F[1:0]!=0, PC_F<IM_BASE, or PC_F>=IM_BASE+4*IM_WORDS; in that case Instr_F SHALL be 32'h0000_0000 (nop) and PC_F SHALL still advance per REQ-020..026.
REQ-034 Without F_ADEL_CHECK_EN, the ExcAdEL_F port and all range/alignment logic SHALL be absent, and Instr_F SHALL always equal InstrMem_Rdata.

Structure
REQ-035 A shared package SHALL hold the NPCOp encodings (NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_JR) and the reset-PC constant, both used by the decode-stage controller.
REQ-036 One sub-module, f_npc (a purely combinational next-PC calculator), SHALL be instantiated; the PC register and the exception logic SHALL remain in f_fetch_stage.

Verification
REQ-037 Reset test: hold reset 2 cycles, then release with SEQ and no stall -> PC_F sequence 0x3000, 0x3004, 0x3008.
REQ-038 Stall test: from PC_F=0x3010, Stop_F=1 for 3 cycles -> PC_F stays 0x3010; on release it goes to 0x3014 next edge.
REQ-039 Branch test: PC_D=0x3020, Imm16_D=16'hFFFC, BRANCH, taken -> next PC_F=0x3014; with BranchTaken_D=0 -> PC_F+4.
REQ-040 Jump/JR test: PC_D=0x3040, Index26_D=26'h0C10, JUMP -> 0x0000_3040; JR with RegRs_D=0x3100 -> 0x3100.
REQ-041 Stall+redirect test: Stop_F=1 and JUMP in the same cycle -> PC_F holds.
REQ-042 Stall+redirect test, next cycle: Stop_F=0, JUMP still present -> the jump target is loaded.
REQ-043 Address-error test (F_ADEL_CHECK_EN defined): JR with RegRs_D=0x3102 -> ExcAdEL_F=1 and Instr_F=0.
REQ-044 Address-error test, out of range (F_ADEL_CHECK_EN defined): JR with RegRs_D=0x7000 -> ExcAdEL_F=1.
REQ-045 Address-error test, legal address (F_ADEL_CHECK_EN defined): JR with RegRs_D=0x3000 -> ExcAdEL_F=0.
